// File: rtl/tilemap_loader_pkg.sv
// Shared tilemap constants: tile codes, RLE word layout and the loader state encoding.
// The collision detector and background drawer import the tile codes from here as well.
package tilemap_loader_pkg;

    localparam logic [2:0] TILE_EMPTY = 3'd0;
    localparam logic [2:0] TILE_END   = 3'd7;

    localparam int RLE_CODE_HI = 7;
    localparam int RLE_CODE_LO = 5;
    localparam int RLE_LEN_HI  = 4;
    localparam int RLE_LEN_LO  = 0;

    localparam int RAM_AW = 15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_WRITE,
        S_FILL,
        S_FINISH
    } loader_state_t;

    function automatic logic [2:0] rle_code(input logic [7:0] word);
        return word[RLE_CODE_HI:RLE_CODE_LO];
    endfunction

    function automatic logic [4:0] rle_len(input logic [7:0] word);
        return word[RLE_LEN_HI:RLE_LEN_LO];
    endfunction

endpackage

// File: rtl/tilemap_loader_if.sv
// Control, level-ROM and tilemap-RAM write signals of the tilemap loader.
// The master side is the loader; the slave side is the system that starts it and hosts ROM/RAM.
interface tilemap_loader_if #(
    parameter int ROM_AW = 10
);
    import tilemap_loader_pkg::*;

    logic              start;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic [RAM_AW-1:0] ram_address;
    logic [2:0]        ram_data;
    logic              ram_we;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        input  start, rom_data,
        output rom_addr, ram_address, ram_data, ram_we, busy, done, error
    );

    modport slave (
        output start, rom_data,
        input  rom_addr, ram_address, ram_data, ram_we, busy, done, error
    );

endinterface

// File: rtl/tilemap_loader_tile_address_counter.sv
// Row-major tile walker: x/y counters with a registered linear RAM address and a last-tile flag.
// Readers of the tilemap can reuse it to scan the map in the same order the loader fills it.
module tile_address_counter
    import tilemap_loader_pkg::*;
#(
    parameter int TILEMAP_LENGTH = 100,
    parameter int TILEMAP_HEIGHT = 15
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              clear,
    input  logic              enable,
    output logic [RAM_AW-1:0] address,
    output logic              last
);

    localparam int TOTAL = TILEMAP_LENGTH * TILEMAP_HEIGHT;
    localparam int XW    = $clog2(TILEMAP_LENGTH);
    localparam int YW    = $clog2(TILEMAP_HEIGHT);

    logic [XW-1:0] tile_x, next_x;
    logic [YW-1:0] tile_y, next_y;

    always_comb begin
        next_x = tile_x + 1'b1;
        next_y = tile_y;
        if (tile_x == XW'(TILEMAP_LENGTH - 1)) begin
            next_x = '0;
            next_y = (tile_y == YW'(TILEMAP_HEIGHT - 1)) ? '0 : tile_y + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tile_x  <= '0;
            tile_y  <= '0;
            address <= '0;
        end else if (clear) begin
            tile_x  <= '0;
            tile_y  <= '0;
            address <= '0;
        end else if (enable) begin
            tile_x  <= next_x;
            tile_y  <= next_y;
            address <= RAM_AW'(next_y) * RAM_AW'(TILEMAP_LENGTH) + RAM_AW'(next_x);
        end
    end

    assign last = (address == RAM_AW'(TOTAL - 1));

endmodule

// File: rtl/tilemap_loader.sv
// Decodes a run-length-encoded level from the level ROM into the tilemap RAM, one tile per cycle.
// done pulses once every address 0..TOTAL-1 has been written; error flags overrun or ROM exhaustion.
module tilemap_loader
    import tilemap_loader_pkg::*;
#(
    parameter int TILEMAP_LENGTH = 100,
    parameter int TILEMAP_HEIGHT = 15,
    parameter int ROM_AW         = 10
) (
    input  logic               clock,
    input  logic               resetn,
    tilemap_loader_if.master   bus
);

    loader_state_t     state;
    logic [4:0]        run_cnt;
    logic              cnt_clear;
    logic              cnt_last;
    logic [RAM_AW-1:0] cnt_address;

    assign cnt_clear = (state == S_IDLE) && bus.start;

    // ram_we is high exactly in WRITE/FILL, so it doubles as the walker's step enable.
    tile_address_counter #(
        .TILEMAP_LENGTH (TILEMAP_LENGTH),
        .TILEMAP_HEIGHT (TILEMAP_HEIGHT)
    ) u_counter (
        .clock   (clock),
        .resetn  (resetn),
        .clear   (cnt_clear),
        .enable  (bus.ram_we),
        .address (cnt_address),
        .last    (cnt_last)
    );

    assign bus.ram_address = cnt_address;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            run_cnt      <= '0;
            bus.rom_addr <= '0;
            bus.ram_data <= '0;
            bus.ram_we   <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.error    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state        <= S_FETCH;
                        bus.rom_addr <= '0;
                        bus.error    <= 1'b0;
                        bus.busy     <= 1'b1;
                    end
                end
                S_FETCH: state <= S_LATCH;
                S_LATCH: begin
                    run_cnt    <= rle_len(bus.rom_data);
                    bus.ram_we <= 1'b1;
                    if (rle_code(bus.rom_data) == TILE_END) begin
                        state        <= S_FILL;
                        bus.ram_data <= TILE_EMPTY;
                    end else begin
                        state        <= S_WRITE;
                        bus.ram_data <= rle_code(bus.rom_data);
                    end
                end
                S_WRITE: begin
                    run_cnt <= run_cnt - 1'b1;
                    // Map full wins over run end: a run still pending here is an overrun.
                    if (cnt_last) begin
                        state      <= S_FINISH;
                        bus.ram_we <= 1'b0;
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                        if (run_cnt != '0) bus.error <= 1'b1;
                    end else if (run_cnt == '0) begin
                        if (&bus.rom_addr) begin
                            state        <= S_FILL;
                            bus.error    <= 1'b1;
                            bus.ram_data <= TILE_EMPTY;
                        end else begin
                            state        <= S_FETCH;
                            bus.ram_we   <= 1'b0;
                            bus.rom_addr <= bus.rom_addr + 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (cnt_last) begin
                        state      <= S_FINISH;
                        bus.ram_we <= 1'b0;
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tilemap_loader.sv
// Scoreboard bench for tilemap_loader: directed level ROMs, expected writes queued, checked by a monitor.
module tb_tilemap_loader;
    import tilemap_loader_pkg::*;

    localparam int TOTAL = 1500;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    tilemap_loader_if #(.ROM_AW(10)) bus_a ();
    tilemap_loader_if #(.ROM_AW(2))  bus_b ();

    tilemap_loader #(.TILEMAP_LENGTH(100), .TILEMAP_HEIGHT(15), .ROM_AW(10)) dut_a (
        .clock(clock), .resetn(resetn), .bus(bus_a));
    tilemap_loader #(.TILEMAP_LENGTH(100), .TILEMAP_HEIGHT(15), .ROM_AW(2)) dut_b (
        .clock(clock), .resetn(resetn), .bus(bus_b));

    logic [7:0] rom_a [1024];
    logic [7:0] rom_b [4];

    always @(posedge clock) begin
        bus_a.rom_data <= rom_a[bus_a.rom_addr];
        bus_b.rom_data <= rom_b[bus_b.rom_addr];
    end

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [17:0] exp_q[$];
    int exp_next = 0;
    int n_writes = 0;
    int first_we_cyc = -1;
    int last_we_cyc = 0;
    int prev_addr = 0;
    int done_cnt = 0;
    int err_at_done = 0;
    int max_rom_a = 0;
    bit chk_gap = 1'b0;
    bit prev_done = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_run(input int code, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({15'(exp_next), 3'(code)});
            exp_next++;
        end
    endtask

    task automatic mon_write(input int addr, input int data);
        logic [17:0] e;
        check("addr_in_map", int'(addr < TOTAL), 1);
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: got addr %0d data %0d, expected no write", addr, data);
        end else begin
            e = exp_q.pop_front();
            check("wr_addr", addr, int'(e[17:3]));
            check("wr_data", data, int'(e[2:0]));
        end
        if (addr == 100) check("row_wrap_prev_addr", prev_addr, 99);
        if (chk_gap && addr == 32) check("run_gap_cycles", cyc - last_we_cyc, 3);
        if (first_we_cyc < 0) first_we_cyc = cyc;
        last_we_cyc = cyc;
        prev_addr = addr;
        n_writes++;
    endtask

    // Monitor: consumes the scoreboard on every write strobe of either instance
    always @(negedge clock) begin
        if (resetn && bus_a.ram_we) mon_write(int'(bus_a.ram_address), int'(bus_a.ram_data));
        if (resetn && bus_b.ram_we) mon_write(int'(bus_b.ram_address), int'(bus_b.ram_data));
        if (bus_a.done || bus_b.done) begin
            check("done_single_cycle", int'(prev_done), 0);
            done_cnt++;
            err_at_done = bus_a.done ? int'(bus_a.error) : int'(bus_b.error);
        end
        prev_done = bus_a.done || bus_b.done;
        if (bus_a.busy && int'(bus_a.rom_addr) > max_rom_a) max_rom_a = int'(bus_a.rom_addr);
    end

    task automatic set_start(input int which, input logic v);
        if (which == 0) bus_a.start = v;
        else bus_b.start = v;
    endtask

    task automatic begin_load(input int which, output int start_cyc);
        first_we_cyc = -1;
        n_writes = 0;
        done_cnt = 0;
        max_rom_a = 0;
        @(negedge clock);
        set_start(which, 1'b1);
        start_cyc = cyc;
        @(negedge clock);
        set_start(which, 1'b0);
        check("busy_after_start", int'(which == 0 ? bus_a.busy : bus_b.busy), 1);
        check("error_cleared_on_start", int'(which == 0 ? bus_a.error : bus_b.error), 0);
    endtask

    task automatic finish_load(input int which, input int start_cyc, input int exp_err, input bit chk_lat);
        int budget;
        budget = 0;
        while (done_cnt == 0 && budget < 4000) begin
            @(negedge clock);
            budget++;
        end
        if (done_cnt == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", budget);
        end
        repeat (3) @(negedge clock);
        check("done_count", done_cnt, 1);
        check("error_at_done", err_at_done, exp_err);
        check("error_sticky", int'(which == 0 ? bus_a.error : bus_b.error), exp_err);
        check("write_count", n_writes, TOTAL);
        check("scoreboard_empty", exp_q.size(), 0);
        check("busy_after_done", int'(which == 0 ? bus_a.busy : bus_b.busy), 0);
        if (chk_lat) check("first_we_latency", first_we_cyc - start_cyc, 3);
        exp_q.delete();
        exp_next = 0;
    endtask

    task automatic wait_writes(input int n);
        int budget;
        budget = 0;
        while (n_writes < n && budget < 4000) begin
            @(negedge clock);
            budget++;
        end
        if (n_writes < n) begin
            vectors++;
            miscompares++;
            $display("FAIL write_wait_timeout: got %0d writes, expected %0d", n_writes, n);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a"}, int'({bus_a.rom_addr, bus_a.ram_address, bus_a.ram_data,
                                 bus_a.ram_we, bus_a.busy, bus_a.done, bus_a.error}), 0);
        check({tag, "_b"}, int'({bus_b.rom_addr, bus_b.ram_address, bus_b.ram_data,
                                 bus_b.ram_we, bus_b.busy, bus_b.done, bus_b.error}), 0);
    endtask

    initial begin
        int sc;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        for (int i = 0; i < 1024; i++) rom_a[i] = 8'hFF;
        for (int i = 0; i < 4; i++) rom_b[i] = 8'h20;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset_outputs");
        resetn = 1'b1;

        // Short run then END word: zero fill of the remainder
        rom_a[0] = 8'h24;
        rom_a[1] = 8'hFF;
        push_run(1, 5);
        push_run(0, 1495);
        begin_load(0, sc);
        finish_load(0, sc, 0, 1'b1);

        // Exact fill with no END word; also run gap and row wrap timing
        for (int i = 0; i < 46; i++) rom_a[i] = 8'h5F;
        rom_a[46] = 8'h5B;
        push_run(2, 1500);
        chk_gap = 1'b1;
        begin_load(0, sc);
        finish_load(0, sc, 0, 1'b1);
        chk_gap = 1'b0;
        check("rom_addr_max", max_rom_a, 46);

        // Overrun: 47 runs of 32 tiles
        rom_a[46] = 8'h5F;
        push_run(2, 1500);
        begin_load(0, sc);
        finish_load(0, sc, 1, 1'b1);

        // Start while busy is ignored, then reset mid-load, then a full reload
        rom_a[0] = 8'h24;
        rom_a[1] = 8'hFF;
        push_run(1, 5);
        push_run(0, 1495);
        begin_load(0, sc);
        wait_writes(300);
        bus_a.start = 1'b1;
        @(negedge clock);
        bus_a.start = 1'b0;
        wait_writes(700);
        resetn = 1'b0;
        #1;
        check_reset_outputs("async_reset_outputs");
        @(posedge clock);
        #1;
        check_reset_outputs("reset_held_outputs");
        exp_q.delete();
        exp_next = 0;
        @(negedge clock);
        resetn = 1'b1;
        push_run(1, 5);
        push_run(0, 1495);
        begin_load(0, sc);
        finish_load(0, sc, 0, 1'b1);

        // Tiny ROM exhausted without END: fill with empty, error raised
        push_run(1, 4);
        push_run(0, 1496);
        begin_load(1, sc);
        finish_load(1, sc, 1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
